// File: rtl/dkong_pkg.sv
// dkong_pkg: shared ROM download constants and loader state type
package dkong_pkg;
  localparam int ROM_AW = 19;
  localparam int ROM_DW = 8;
  localparam int unsigned IMG_LEN = 'h0E000;
  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, GAP, DONE} loader_state_t;
endpackage

// File: rtl/dkong_gap_timer.sv
// dkong_gap_timer: loadable down-counter with zero flag for write cadence
module dkong_gap_timer #(
  parameter int W = 4
) (
  input  logic         I_CLK_24576M,
  input  logic         I_RESET,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge I_CLK_24576M)
    if (I_RESET) cnt <= '0;
    else if (load) cnt <= val;
    else if (!zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/dkong_rom_loader.sv
// dkong_rom_loader: ready/valid byte stream to ROM RAM download port with checksum
module dkong_rom_loader
  import dkong_pkg::*;
#(
  parameter int unsigned BASE   = 0,
  parameter int unsigned LENGTH = IMG_LEN,
  parameter int unsigned WR_GAP = 1
) (
  input  logic              I_CLK_24576M,
  input  logic              I_RESET,
  input  logic              I_START,
  input  logic              I_ABORT,
  input  logic [ROM_DW-1:0] I_DAT,
  input  logic              I_VALID,
  output logic              O_READY,
  output logic [ROM_AW-1:0] dn_addr,
  output logic [ROM_DW-1:0] dn_data,
  output logic              dn_wr,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_ERR,
  output logic [ROM_DW-1:0] O_CSUM
);
  localparam logic [ROM_AW:0] LEN    = (ROM_AW + 1)'(LENGTH);
  localparam logic [3:0]      GAP_LD = 4'(WR_GAP - 1);
  if (BASE + LENGTH > (1 << ROM_AW) || LENGTH == 0 || WR_GAP > 15) begin : g_bad_params
    $error("dkong_rom_loader: BASE/LENGTH/WR_GAP out of range");
  end
  loader_state_t   state;
  logic [ROM_AW:0] cnt;
  logic [ROM_AW:0] cnt_inc;
  logic            gap_zero;
  assign cnt_inc = cnt + 1'b1;
  dkong_gap_timer #(.W(4)) u_gap (
    .I_CLK_24576M(I_CLK_24576M),
    .I_RESET     (I_RESET),
    .load        (state == WRITE),
    .val         (GAP_LD),
    .zero        (gap_zero)
  );
  // The byte in WRITE is already on the RAM port, so it counts even if aborted.
  always_ff @(posedge I_CLK_24576M)
    if (I_RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      dn_addr <= '0;
      dn_data <= '0;
      dn_wr   <= 1'b0;
      O_READY <= 1'b0;
      O_BUSY  <= 1'b0;
      O_DONE  <= 1'b0;
      O_ERR   <= 1'b0;
      O_CSUM  <= '0;
    end else begin
      dn_wr <= 1'b0;
      if (state == WRITE) begin
        O_CSUM <= O_CSUM + dn_data;
        cnt    <= cnt_inc;
      end
      if (O_BUSY && I_ABORT) begin
        state   <= IDLE;
        O_READY <= 1'b0;
        O_BUSY  <= 1'b0;
        O_DONE  <= 1'b0;
        O_ERR   <= 1'b1;
      end else if (!O_BUSY && I_START) begin
        state   <= I_ABORT ? IDLE : ACCEPT;
        O_READY <= !I_ABORT;
        O_BUSY  <= !I_ABORT;
        O_ERR   <= I_ABORT;
        O_DONE  <= 1'b0;
        O_CSUM  <= '0;
        cnt     <= '0;
      end else begin
        case (state)
          ACCEPT: if (I_VALID) begin
            dn_data <= I_DAT;
            dn_addr <= ROM_AW'(BASE + cnt);
            dn_wr   <= 1'b1;
            O_READY <= 1'b0;
            state   <= WRITE;
          end
          WRITE: if (cnt_inc == LEN) begin
            state  <= DONE;
            O_BUSY <= 1'b0;
            O_DONE <= 1'b1;
          end else if (WR_GAP == 0) begin
            state   <= ACCEPT;
            O_READY <= 1'b1;
          end else state <= GAP;
          GAP: if (gap_zero) begin
            state   <= ACCEPT;
            O_READY <= 1'b1;
          end
          default: ;
        endcase
      end
    end
endmodule
